// File: rtl/canvas_brush_painter.sv
// Drawing-canvas editor: maps the cursor to a GRIDxGRID cell array and stamps a plus-shaped
// brush (paint or erase), one cell write per clock, with a column-per-clock clear sweep.
module canvas_brush_painter #(
    parameter int GRID     = 28,
    parameter int CELL_PX  = 14,
    parameter int ORIGIN_X = 199,
    parameter int ORIGIN_Y = 43,
    parameter int PIX_W    = 16,
    parameter int CTR_VAL  = 2000,
    parameter int SIDE_INC = 700,
    parameter int SIDE_MAX = 2000
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Erase,
    input  logic             Clear,
    input  logic [9:0]       X_Pos,
    input  logic [9:0]       Y_Pos,
    output logic [PIX_W-1:0] canvas [GRID][GRID],
    output logic             busy,
    output logic [15:0]      stamps
);
    // state | meaning
    // IDLE  | waiting for Run or Clear
    // S_C   | write centre cell
    // S_L   | update left neighbour (cx-1)
    // S_R   | update right neighbour (cx+1)
    // S_U   | update upper neighbour (cy-1)
    // S_D   | update lower neighbour (cy+1), count the stamp
    // CLR   | clear one column per edge
    typedef enum logic [2:0] {IDLE, S_C, S_L, S_R, S_U, S_D, CLR} state_t;

    localparam int CW = $clog2(GRID);
    localparam logic [9:0]       OX     = 10'(ORIGIN_X);
    localparam logic [9:0]       OY     = 10'(ORIGIN_Y);
    localparam logic [9:0]       CPX    = 10'(CELL_PX);
    localparam logic [9:0]       GRID10 = 10'(GRID);
    localparam logic [CW-1:0]    LAST   = CW'(GRID - 1);
    localparam logic [PIX_W-1:0] CTR    = PIX_W'(CTR_VAL);
    localparam logic [PIX_W-1:0] INC    = PIX_W'(SIDE_INC);
    localparam logic [PIX_W:0]   INC_X  = (PIX_W+1)'(SIDE_INC);
    localparam logic [PIX_W:0]   MAX_X  = (PIX_W+1)'(SIDE_MAX);

    state_t        state;
    logic [CW-1:0] cx_l, cy_l, col;
    logic          erase_l;

    logic [9:0]       x_off, y_off, cx_raw, cy_raw;
    logic             in_grid;
    logic [CW-1:0]    tx, ty;
    logic             t_ok;
    logic [PIX_W-1:0] cur_v, nb_v;
    logic [PIX_W:0]   sum;

    always_comb begin
        x_off   = X_Pos - OX;
        y_off   = Y_Pos - OY;
        cx_raw  = x_off / CPX;
        cy_raw  = y_off / CPX;
        in_grid = (X_Pos >= OX) && (Y_Pos >= OY) && (cx_raw < GRID10) && (cy_raw < GRID10);
    end

    // Neighbour target for the current stamp state; t_ok drops when it falls off the grid edge.
    always_comb begin
        tx   = cx_l;
        ty   = cy_l;
        t_ok = 1'b0;
        case (state)
            S_L: begin tx = cx_l - 1'b1; t_ok = (cx_l != '0);  end
            S_R: begin tx = cx_l + 1'b1; t_ok = (cx_l != LAST); end
            S_U: begin ty = cy_l - 1'b1; t_ok = (cy_l != '0);  end
            S_D: begin ty = cy_l + 1'b1; t_ok = (cy_l != LAST); end
            default: ;
        endcase
        cur_v = t_ok ? canvas[tx][ty] : '0;
        sum   = {1'b0, cur_v} + INC_X;
        if (erase_l)
            nb_v = (cur_v > INC) ? cur_v - INC : '0;
        else
            nb_v = (sum > MAX_X) ? MAX_X[PIX_W-1:0] : sum[PIX_W-1:0];
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int x = 0; x < GRID; x++)
                for (int y = 0; y < GRID; y++)
                    canvas[x][y] <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            stamps  <= '0;
            cx_l    <= '0;
            cy_l    <= '0;
            erase_l <= 1'b0;
            col     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Clear) begin
                        state <= CLR;
                        busy  <= 1'b1;
                        col   <= '0;
                    end else if (Run && in_grid) begin
                        cx_l    <= cx_raw[CW-1:0];
                        cy_l    <= cy_raw[CW-1:0];
                        erase_l <= Erase;
                        state   <= S_C;
                        busy    <= 1'b1;
                    end
                end
                CLR: begin
                    for (int y = 0; y < GRID; y++)
                        canvas[col][y] <= '0;
                    if (col == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: begin
                    // Clear aborts a stamp without writing or counting it.
                    if (Clear) begin
                        state <= CLR;
                        col   <= '0;
                    end else begin
                        if (state == S_C)
                            canvas[cx_l][cy_l] <= erase_l ? '0 : CTR;
                        else if (t_ok)
                            canvas[tx][ty] <= nb_v;
                        case (state)
                            S_C:     state <= S_L;
                            S_L:     state <= S_R;
                            S_R:     state <= S_U;
                            S_U:     state <= S_D;
                            default: begin
                                state  <= IDLE;
                                busy   <= 1'b0;
                                stamps <= stamps + 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule
